// File: rtl/rs232_tx_arbiter.sv
// rtl/rs232_tx_arbiter.sv - round-robin arbiter sharing one quick_rs232 transmitter between byte sources
module rs232_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int HOLD_CYCLES  = 10,
    parameter int COPY_TIMEOUT = 65535
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ack,
    output logic [2:0]           grant_id,
    output logic                 busy,
    output logic                 tx_timeout,
    output logic                 tx_transaction,
    output logic [7:0]           tx_data,
    output logic                 tx_data_ready,
    input  logic                 tx_data_copied,
    input  logic                 tx_busy
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_HOLD, S_RELEASE} state_t;

    localparam logic [3:0]  NR         = 4'(NUM_REQ);
    localparam logic [2:0]  LAST_ID    = 3'(NUM_REQ - 1);
    localparam logic [15:0] COPY_LIMIT = 16'(COPY_TIMEOUT - 1);
    localparam logic [15:0] HOLD_LIMIT = 16'(HOLD_CYCLES - 1);

    state_t               state, state_next;
    logic                 lock, lock_next;
    logic [15:0]          cnt, cnt_next;
    logic [2:0]           grant_next;
    logic [7:0]           tx_data_next;
    logic                 tx_transaction_next, tx_data_ready_next, tx_timeout_next;
    logic [NUM_REQ-1:0]   req_ack_next;

    logic [2:0]           start_id, search_id, pick_id;
    logic [NUM_REQ-1:0]   scan;
    logic [3:0]           off, sum;
    logic                 found, locked_ok, pick_any, pick_last, do_capture;
    logic [7:0]           pick_data;

    assign busy = (state != S_IDLE);

    // Rotate the request vector so the search always begins just after the last grant.
    always_comb begin
        start_id = (grant_id >= LAST_ID) ? 3'd0 : grant_id + 3'd1;
        scan     = NUM_REQ'({req_valid, req_valid} >> start_id);
        found    = 1'b0;
        off      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && scan[0]) begin
                found = 1'b1;
                off   = 4'(k);
            end
            scan = scan >> 1;
        end
        sum = {1'b0, start_id} + off;
        if (sum >= NR) begin
            sum = sum - NR;
        end
        search_id = sum[2:0];
    end

    always_comb begin
        locked_ok = lock & 1'(req_valid >> grant_id);
        pick_id   = locked_ok ? grant_id : search_id;
        pick_any  = locked_ok | found;
        pick_data = 8'(req_data >> {pick_id, 3'b000});
        pick_last = 1'(req_last >> pick_id);
    end

    always_comb begin
        state_next          = state;
        lock_next           = lock;
        cnt_next            = cnt;
        grant_next          = grant_id;
        tx_data_next        = tx_data;
        tx_transaction_next = tx_transaction;
        tx_data_ready_next  = tx_data_ready;
        tx_timeout_next     = 1'b0;
        req_ack_next        = '0;
        do_capture          = 1'b0;

        case (state)
            S_IDLE: begin
                tx_transaction_next = 1'b0;
                do_capture          = pick_any;
            end
            S_LOAD: begin
                // A copy arriving on the expiry cycle wins over the timeout.
                if (tx_data_copied) begin
                    cnt_next   = '0;
                    state_next = S_HOLD;
                end else if (cnt == COPY_LIMIT) begin
                    tx_timeout_next     = 1'b1;
                    tx_data_ready_next  = 1'b0;
                    tx_transaction_next = 1'b0;
                    lock_next           = 1'b0;
                    cnt_next            = '0;
                    state_next          = S_IDLE;
                end else begin
                    cnt_next = cnt + 16'd1;
                end
            end
            S_HOLD: begin
                if (cnt == HOLD_LIMIT) begin
                    tx_data_ready_next = 1'b0;
                    cnt_next           = '0;
                    state_next         = S_RELEASE;
                end else begin
                    cnt_next = cnt + 16'd1;
                end
            end
            S_RELEASE: begin
                if (!tx_busy) begin
                    if (locked_ok) begin
                        do_capture = 1'b1;
                    end else begin
                        tx_transaction_next = 1'b0;
                        state_next          = S_IDLE;
                    end
                end
            end
            default: state_next = S_IDLE;
        endcase

        if (do_capture) begin
            tx_data_next        = pick_data;
            grant_next          = pick_id;
            req_ack_next        = (NUM_REQ)'(1) << pick_id;
            lock_next           = ~pick_last;
            tx_transaction_next = 1'b1;
            tx_data_ready_next  = 1'b1;
            cnt_next            = '0;
            state_next          = S_LOAD;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= S_IDLE;
            lock           <= 1'b0;
            cnt            <= '0;
            grant_id       <= LAST_ID;
            tx_data        <= '0;
            tx_transaction <= 1'b0;
            tx_data_ready  <= 1'b0;
            tx_timeout     <= 1'b0;
            req_ack        <= '0;
        end else begin
            state          <= state_next;
            lock           <= lock_next;
            cnt            <= cnt_next;
            grant_id       <= grant_next;
            tx_data        <= tx_data_next;
            tx_transaction <= tx_transaction_next;
            tx_data_ready  <= tx_data_ready_next;
            tx_timeout     <= tx_timeout_next;
            req_ack        <= req_ack_next;
        end
    end

endmodule

// File: tb/tb_rs232_tx_arbiter.sv
// tb/tb_rs232_tx_arbiter.sv - scoreboard bench for rs232_tx_arbiter with a behavioural serial-core model
module tb_rs232_tx_arbiter;
    localparam int N    = 4;
    localparam int HOLD = 10;
    localparam int CTO  = 100;

    logic           clk, rst;
    logic [N-1:0]   req_valid, req_last, req_ack;
    logic [8*N-1:0] req_data;
    logic [2:0]     grant_id;
    logic           busy, tx_timeout, tx_transaction, tx_data_ready, tx_data_copied, tx_busy;
    logic [7:0]     tx_data;

    rs232_tx_arbiter #(.NUM_REQ(N), .HOLD_CYCLES(HOLD), .COPY_TIMEOUT(CTO)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
        .req_ack(req_ack), .grant_id(grant_id), .busy(busy), .tx_timeout(tx_timeout),
        .tx_transaction(tx_transaction), .tx_data(tx_data), .tx_data_ready(tx_data_ready),
        .tx_data_copied(tx_data_copied), .tx_busy(tx_busy)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    typedef struct { logic [7:0] data; bit last; } item_t;
    typedef struct { int req; logic [7:0] data; bit drop; } exp_t;

    int    total = 0, bad = 0;
    item_t stg[N][$];
    item_t drv_q[N][$];
    exp_t  exp_q[$];
    bit    drop_q[$];
    int    ack_log[$];
    exp_t  cur;
    bit    have_cur = 0;
    int    mg = N - 1;
    bit    mlock = 0;
    int    exp_drops = 0, n_to = 0;
    int    copy_dly = -1, busy_len = -1;
    int    e_rr[5], e_lock[4], e_rst[2];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference: whole-transaction order from round-robin + packet-lock rules over the queued bytes.
    task automatic launch(input int drop_mode);
        item_t mq[N][$];
        int    left = 0;
        for (int i = 0; i < N; i++) begin
            mq[i] = stg[i];
            left += stg[i].size();
        end
        while (left > 0) begin
            int    w = -1;
            item_t it;
            bit    d;
            if (mlock && mq[mg].size() > 0) w = mg;
            else
                for (int k = 1; k <= N; k++)
                    if (w < 0 && mq[(mg + k) % N].size() > 0) w = (mg + k) % N;
            it = mq[w].pop_front();
            d  = (drop_mode == 2) || (drop_mode == 0 && $urandom_range(0, 9) == 0);
            exp_q.push_back('{w, it.data, d});
            drop_q.push_back(d);
            if (d) exp_drops++;
            mg    = w;
            mlock = d ? 1'b0 : !it.last;
            left--;
        end
        for (int i = 0; i < N; i++) begin
            foreach (stg[i][j]) drv_q[i].push_back(stg[i][j]);
            stg[i].delete();
        end
    endtask

    function automatic bit drv_empty();
        for (int i = 0; i < N; i++) if (drv_q[i].size() != 0) return 0;
        return 1;
    endfunction

    task automatic drain(input string tag);
        int c = 0;
        while (c < 20000 && !(exp_q.size() == 0 && drv_empty() && !busy)) begin
            @(posedge clk); #1;
            c++;
        end
        chk({"drain_", tag}, 64'(c < 20000), 64'(1));
        repeat (2) @(posedge clk);
    endtask

    // Requesters: hold valid until acked, then present the next queued byte.
    initial begin
        req_valid = '0; req_data = '0; req_last = '0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < N; i++)
                if (req_ack[i] && drv_q[i].size() > 0) void'(drv_q[i].pop_front());
            for (int i = 0; i < N; i++) begin
                if (drv_q[i].size() > 0) begin
                    req_valid[i]       = 1'b1;
                    req_data[8*i +: 8] = drv_q[i][0].data;
                    req_last[i]        = drv_q[i][0].last;
                end else begin
                    req_valid[i]       = 1'b0;
                    req_data[8*i +: 8] = 8'h00;
                    req_last[i]        = 1'b0;
                end
            end
        end
    end

    // Serial core: copies after a delay (or never, for dropped bytes) then stays busy a while.
    initial begin
        int cst = 0, dly = 0, busy_cnt = 0;
        bit drop;
        tx_data_copied = 1'b0; tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            tx_data_copied = 1'b0;
            if (rst) begin
                cst = 0; busy_cnt = 0; tx_busy = 1'b0;
            end else begin
                if (busy_cnt > 0) busy_cnt--;
                tx_busy = (busy_cnt > 0);
                case (cst)
                    0: if (tx_data_ready) begin
                        drop = (drop_q.size() > 0) ? drop_q.pop_front() : 1'b0;
                        dly  = (copy_dly >= 0) ? copy_dly : $urandom_range(0, 5);
                        cst  = drop ? 2 : 1;
                    end
                    1: if (!tx_data_ready) cst = 0;
                       else if (dly == 0) begin
                        tx_data_copied = 1'b1;
                        chk("copied_data", 64'(tx_data), 64'(cur.data));
                        chk("copied_not_dropped", 64'(cur.drop), 64'(0));
                        busy_cnt = (busy_len >= 0) ? busy_len : $urandom_range(0, 15);
                        tx_busy  = (busy_cnt > 0);
                        cst      = 3;
                    end else dly--;
                    default: if (!tx_data_ready) cst = 0;
                endcase
            end
        end
    end

    // Monitor: each ack pops the next expected grant; each timeout must match a dropped byte.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (req_ack != '0) begin
                    ack_log.push_back(int'(grant_id));
                    if (exp_q.size() == 0) chk("unexpected_ack", 64'(req_ack), 64'(0));
                    else begin
                        e = exp_q.pop_front();
                        chk("ack_vec", 64'(req_ack), 64'(1) << e.req);
                        chk("grant_id", 64'(grant_id), 64'(e.req));
                        chk("tx_data", 64'(tx_data), 64'(e.data));
                        chk("ready_with_ack", 64'({tx_transaction, tx_data_ready}), 64'(3));
                        cur = e;
                        have_cur = 1;
                    end
                end
                if (tx_timeout) begin
                    n_to++;
                    chk("timeout_expected", 64'(have_cur && cur.drop), 64'(1));
                end
            end
        end
    end

    initial begin
        int c;
        e_rr   = '{0, 1, 2, 3, 0};
        e_lock = '{2, 2, 2, 1};
        e_rst  = '{0, 1};
        rst = 1'b1;
        repeat (3) @(posedge clk); #1;
        chk("rst_outputs", 64'({req_ack, tx_transaction, tx_data_ready, tx_timeout, busy, tx_data}), 64'(0));
        chk("rst_grant", 64'(grant_id), 64'(N - 1));
        @(negedge clk) rst = 1'b0;

        // round robin, then a refill of requester 0
        ack_log.delete();
        for (int i = 0; i < N; i++) stg[i].push_back('{8'h10 + 8'(i), 1'b1});
        launch(1);
        drain("rr");
        stg[0].push_back('{8'h20, 1'b1});
        launch(1);
        drain("rr_refill");
        chk("rr_len", 64'(ack_log.size()), 64'(5));
        for (int k = 0; k < 5; k++) chk("rr_order", 64'(k < ack_log.size() ? ack_log[k] : -1), 64'(e_rr[k]));

        // single byte with exact handshake timing
        copy_dly = 2; busy_len = 20;
        stg[0].push_back('{8'h41, 1'b1});
        launch(1);
        c = 0;
        while (c < 50 && !req_valid[0]) begin @(posedge clk); #1; c++; end
        chk("single_ack_latency", 64'(req_ack), 64'(1));
        chk("single_data", 64'(tx_data), 64'(8'h41));
        c = 0;
        while (c < 50 && !tx_data_copied) begin @(posedge clk); #1; c++; end
        c = 0;
        while (c < 50 && tx_data_ready) begin @(posedge clk); #1; c++; end
        chk("hold_cycles", 64'(c), 64'(HOLD));
        chk("trans_held_while_busy", 64'({tx_transaction, busy}), 64'(3));
        c = 0;
        while (c < 100 && tx_busy) begin @(posedge clk); #1; c++; end
        chk("trans_drop_after_busy", 64'({tx_transaction, busy}), 64'(0));
        drain("single");
        copy_dly = -1; busy_len = -1;

        // copy timeout, then a normally served byte
        stg[1].push_back('{8'h5A, 1'b1});
        launch(2);
        c = 0;
        while (c < 50 && req_ack == '0) begin @(posedge clk); #1; c++; end
        c = 0;
        while (c < 1000 && !tx_timeout) begin @(posedge clk); #1; c++; end
        chk("timeout_latency", 64'(c), 64'(CTO));
        chk("timeout_outputs", 64'({tx_data_ready, tx_transaction, busy}), 64'(0));
        drain("timeout");
        stg[1].push_back('{8'h33, 1'b1});
        launch(1);
        drain("after_timeout");

        // packet lock: requester 2 sends three bytes ahead of requester 1
        ack_log.delete();
        stg[2].push_back('{8'hA0, 1'b0});
        stg[2].push_back('{8'hA1, 1'b0});
        stg[2].push_back('{8'hA2, 1'b1});
        stg[1].push_back('{8'hB0, 1'b1});
        launch(1);
        c = 0;
        while (c < 2000 && ack_log.size() < 1) begin @(posedge clk); #1; c++; end
        c = 0;
        begin
            int idle = 0;
            while (c < 2000 && ack_log.size() < 3) begin
                @(posedge clk); #1; c++;
                if (!busy) idle++;
            end
            chk("lock_no_idle", 64'(idle), 64'(0));
        end
        drain("lock");
        chk("lock_len", 64'(ack_log.size()), 64'(4));
        for (int k = 0; k < 4; k++) chk("lock_order", 64'(k < ack_log.size() ? ack_log[k] : -1), 64'(e_lock[k]));

        // asynchronous reset in the middle of HOLD
        copy_dly = 0; busy_len = 30;
        stg[3].push_back('{8'hC3, 1'b1});
        launch(1);
        c = 0;
        while (c < 50 && !tx_data_copied) begin @(posedge clk); #1; c++; end
        @(negedge clk); #2;
        rst = 1'b1;
        #1;
        chk("midhold_rst_outputs", 64'({req_ack, tx_transaction, tx_data_ready, tx_timeout, busy, tx_data}), 64'(0));
        chk("midhold_rst_grant", 64'(grant_id), 64'(N - 1));
        mg = N - 1; mlock = 0; have_cur = 0;
        exp_q.delete(); drop_q.delete();
        for (int i = 0; i < N; i++) drv_q[i].delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        copy_dly = -1; busy_len = -1;
        ack_log.delete();
        stg[1].push_back('{8'h61, 1'b1});
        stg[0].push_back('{8'h60, 1'b1});
        launch(1);
        drain("after_rst");
        chk("rst_len", 64'(ack_log.size()), 64'(2));
        for (int k = 0; k < 2; k++) chk("rst_order", 64'(k < ack_log.size() ? ack_log[k] : -1), 64'(e_rst[k]));

        // randomized packets with random copy delays, busy lengths and drops
        for (int r = 0; r < 12; r++) begin
            for (int i = 0; i < N; i++) begin
                int np = $urandom_range(0, 2);
                for (int p = 0; p < np; p++) begin
                    int len = $urandom_range(1, 3);
                    for (int b = 0; b < len; b++) stg[i].push_back('{8'($urandom), b == len - 1});
                end
            end
            launch(0);
            drain("random");
        end

        chk("timeout_count", 64'(n_to), 64'(exp_drops));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/rs232_tx_arbiter.md
Name: rs232_tx_arbiter

Overview:
- Shares the single quick_rs232 transmitter between NUM_REQ independent byte sources, e.g. echo path, status reporter and debug dumper.
- Round-robin arbitration; a grant can be locked for a multi-byte packet.
- Drives the serial core's tx_transaction / tx_data / tx_data_ready handshake and waits for tx_data_copied and then tx_busy low before releasing.
- Sits between application FSMs and quick_rs232 at the top level of the board design.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
HOLD_CYCLES, 10, cycles tx_data_ready is kept high after tx_data_copied
COPY_TIMEOUT, 65535, max cycles to wait for tx_data_copied before the byte is dropped (16-bit counter)

Ports:
clk  in  1  system clock (50 MHz)
rst  in  1  asynchronous, active-high reset
req_valid  in  NUM_REQ  requester i has a byte on req_data[8*i+7:8*i]
req_data  in  8*NUM_REQ  packed request bytes
req_last  in  NUM_REQ  byte from requester i ends its packet (releases lock)
req_ack  out  NUM_REQ  one-cycle pulse: byte of requester i captured
grant_id  out  3  index of current/last granted requester
busy  out  1  arbiter not in IDLE
tx_timeout  out  1  one-cycle pulse: tx_data_copied never arrived
tx_transaction  out  1  to quick_rs232
tx_data  out  8  to quick_rs232
tx_data_ready  out  1  to quick_rs232
tx_data_copied  in  1  from quick_rs232
tx_busy  in  1  from quick_rs232

Behaviour:
- Reset (async assert, sync release): state=IDLE; all outputs 0; grant_id=NUM_REQ-1 so requester 0 wins first; lock=0; counters 0.
- IDLE:
  - Winner = first i with req_valid[i], searching from grant_id+1 modulo NUM_REQ.
  - If lock=1 and req_valid[grant_id]=1, that requester wins regardless of the search.
  - On a win, at the same edge: tx_data<=req_data[winner], grant_id<=winner, req_ack[winner]=1 for exactly that cycle, lock<=~req_last[winner]. Go to LOAD.
  - If no request: stay in IDLE, outputs unchanged except tx_transaction=0.
- LOAD: tx_transaction=1, tx_data_ready=1, tx_data held stable.
  - On tx_data_copied=1: counter<=0, go to HOLD.
  - Timeout counter increments each cycle. If it reaches COPY_TIMEOUT: pulse tx_timeout, tx_data_ready<=0, tx_transaction<=0, lock<=0, go to IDLE. The byte is lost; no further ack is issued.
- HOLD: tx_data_ready stays 1 for HOLD_CYCLES cycles, then tx_data_ready<=0 and go to RELEASE.
- RELEASE: wait for tx_busy=0, then:
  - if lock=1 and req_valid[grant_id]=1: capture the next byte as in IDLE (req_ack pulse) and go directly to LOAD; tx_transaction stays 1;
  - otherwise tx_transaction<=0 and go to IDLE.
- Lock timing:
  - If a locked requester drops req_valid while in RELEASE, the arbiter returns to IDLE and lock stays set.
  - The lock is cleared only by req_last or timeout. Other requesters are starved while it is held; this is intended.
- Latency: req_valid to req_ack is 1 cycle from IDLE; from req_ack to tx_data_ready=1 is 0 cycles (registered together).
- Simultaneous events:
  - req_valid deasserting in the same cycle as the grant is ignored (the byte was already sampled).
  - tx_data_copied arriving on the same cycle as timeout expiry counts as success.
- Reset mid-transfer drops everything immediately; the serial core is reset by the same rst.
- NUM_REQ=1 degenerates to a pass-through with the same handshakes.

Test Plan:
- Single byte: req_valid[0]=1, req_data=0x41, req_last=1. Expect req_ack[0] one cycle later and tx_data=0x41 with tx_data_ready high until 10 cycles after tx_data_copied. tx_transaction falls after tx_busy=0.
- Round-robin: all 4 requesters valid with bytes 0x10..0x13 and req_last=1. Expect transmit order 0,1,2,3, then 0 again on refill. grant_id follows the same sequence.
- Packet lock: requester 2 sends 3 bytes (req_last only on the 3rd) while requester 1 is valid. Expect bytes of 2 back-to-back with no IDLE visit, then requester 1.
- Timeout: tx_data_copied held 0 with COPY_TIMEOUT=100. Expect tx_timeout pulse at cycle 100 of LOAD, tx_data_ready=0 and return to IDLE; the next request is served normally.
- Reset mid-HOLD: assert rst asynchronously. All outputs go to 0 immediately, and after release requester 0 wins first.
- Echo integration: quick_rs232 loopback at 434 ticks/bit with two requesters. Bytes on the tx line match the grant order, with no byte corrupted or duplicated.
